fetch_unit_pipelined: RTL and testbench

Parametrised instruction-fetch stage. It holds a byte-addressed PC that advances by 4 and drives a 1-cycle-latency synchronous instruction-memory port. Returned words and their PCs are buffered in a small fetch queue, and the queue feeds decode over a valid/ready handshake. Branch redirects from execute flush the queue, discard any in-flight response and restart fetch at the target.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_pipelined_fetch_queue.sv | 80 ++++++++
 rtl/fetch_unit_pipelined.sv | 146 ++++++++++++++
 tb/tb_fetch_unit_pipelined.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  // Default PC / address width. The fetch entry type below is built on it,
  // so a top-level XLEN override must match this value.
  localparam int XLEN = 64;

  // addi x0, x0, 0 -- shown on the decode port before anything is fetched.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_pipelined_fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetch entries with a flush input.
// Latency: a push is visible at head_o the cycle after it is written.
// Backpressure: none internally; the owner must never push into a full queue without popping.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i + push_dat_i write;
//        pop_i drops the head; flush_i empties the queue and beats a same-cycle push;
//        count_o occupancy, head_o oldest entry, empty_o no entries held.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Stored data is left in place; only the bookkeeping is cleared.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset: count_q gates whether any slot is meaningful.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // A push into a full queue is only legal when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !flush_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit_pipelined.sv
// Instruction fetch: PC sequencer driving a 1-cycle sync imem, fetch queue to decode, redirect flush.
// Latency: request to inst_valid_o is 2 cycles; redirect target visible 3 cycles after the redirect.
// Backpressure: inst_ready_i low stalls requests once queue entries plus the in-flight word reach FQ_DEPTH.
// Ports: clk_i, reset_i (async active-low); redirect_valid_i/redirect_pc_i from execute;
//        imem_req_o/imem_addr_o/imem_rdata_i memory port; inst_valid_o/inst_ready_i/inst_o/inst_pc_o to decode.
// Optional: define FETCH_PERF_CNT_EN to add saturating counters perf_fetched_o (queue pushes)
//           and perf_stall_o (cycles with a head held by decode).
module fetch_unit_pipelined
  import fetch_pkg::*;
#(
  parameter int              XLEN       = fetch_pkg::XLEN,
  parameter int              IMEM_DEPTH = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FQ_DEPTH   = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [XLEN-1:0]               perf_fetched_o,
  output logic [XLEN-1:0]               perf_stall_o,
`endif
  input  logic                          redirect_valid_i,
  input  logic [XLEN-1:0]               redirect_pc_i,
  output logic                          imem_req_o,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
  input  logic [31:0]                   imem_rdata_i,
  output logic                          inst_valid_o,
  input  logic                          inst_ready_i,
  output logic [31:0]                   inst_o,
  output logic [XLEN-1:0]               inst_pc_o
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic            run_q, run_d;
  fetch_entry_t    last_q, last_d;

  logic [CW-1:0]   fq_count;
  fetch_entry_t    fq_head;
  logic            fq_empty;
  fetch_entry_t    push_dat;
  logic            push;
  logic            pop;
  logic            issue;
  logic [OW-1:0]   occ;

  assign pop  = ~fq_empty & inst_ready_i;
  // A response is dropped if a redirect landed in the cycle its request was issued.
  assign push = inflight_q & ~kill_q;
  assign push_dat = '{pc: req_pc_q, inst: imem_rdata_i};

  // Slots committed after this cycle: queued entries plus the in-flight word, minus the departing head.
  assign occ   = OW'(fq_count) + OW'(inflight_q) - OW'(pop);
  // run_q holds requests off for the first cycle after reset release.
  assign issue = run_q & ~redirect_valid_i & (occ < OW'(FQ_DEPTH));

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk_i      (clk_i),
    .rst_ni     (reset_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (redirect_valid_i),
    .count_o    (fq_count),
    .head_o     (fq_head),
    .empty_o    (fq_empty)
  );

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    kill_d     = redirect_valid_i;
    run_d      = 1'b1;
    last_d     = fq_empty ? last_q : fq_head;
    if (redirect_valid_i) begin
      // Misaligned targets are rounded down to the containing word.
      pc_d = redirect_pc_i & ~XLEN'(3);
    end else if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      run_q      <= 1'b0;
      last_q     <= '{pc: '0, inst: NOP_INST};
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      run_q      <= run_d;
      last_q     <= last_d;
    end
  end

  assign imem_req_o   = issue;
  assign imem_addr_o  = pc_q[AW+1:2];
  assign inst_valid_o = ~fq_empty;
  // With the queue empty the decode port keeps showing the last head it presented.
  assign inst_o       = fq_empty ? last_q.inst : fq_head.inst;
  assign inst_pc_o    = fq_empty ? last_q.pc   : fq_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
  logic [XLEN-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    // A push coinciding with a flush never lands in the queue, so it is not counted.
    if (push && !redirect_valid_i && perf_fetched_q != '1) begin
      perf_fetched_d = perf_fetched_q + XLEN'(1);
    end
    if (inst_valid_o && !inst_ready_i && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Bench for fetch_unit_pipelined: directed scenarios plus randomized ready/redirect/reset traffic,
// checked every cycle against a queue-based model of the fetch rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fetch_unit_pipelined;

  localparam int          XLEN       = 64;
  localparam int          IMEM_DEPTH = 32;
  localparam int          FQ_DEPTH   = 2;
  localparam logic [63:0] RESET_PC   = 64'h0;

  logic        clk_i;
  logic        reset_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_o;
  logic [4:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched_o;
  logic [63:0] perf_stall_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit_pipelined #(
    .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched_o   (perf_fetched_o),
    .perf_stall_o     (perf_stall_o),
`endif
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] word(input int idx);
    return 32'h1000_0000 + 32'(idx);
  endfunction

  // Synchronous instruction memory: data appears the cycle after the request.
  initial imem_rdata_i = 32'h0;
  always @(posedge clk_i) begin
    if (imem_req_o) imem_rdata_i <= word(int'(imem_addr_o));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last;
  logic [63:0] m_pc, m_req_pc;
  bit          m_inflight, m_kill, m_run;
  logic [63:0] m_fetched, m_stall;

  function automatic void m_reset();
    mq.delete();
    m_pc       = RESET_PC;
    m_req_pc   = '0;
    m_inflight = 0;
    m_kill     = 0;
    m_run      = 0;
    m_last.pc   = '0;
    m_last.inst = 32'h0000_0013;
    m_fetched  = '0;
    m_stall    = '0;
  endfunction

  initial m_reset();

  always @(negedge clk_i) begin
    ent_t exp_head;
    ent_t e;
    bit   exp_valid, exp_pop, exp_req, resp;
    int   occ;
    if (!reset_i) m_reset();
    exp_valid = (mq.size() != 0);
    exp_head  = exp_valid ? mq[0] : m_last;
    exp_pop   = exp_valid && inst_ready_i;
    occ       = mq.size() + int'(m_inflight) - int'(exp_pop);
    exp_req   = m_run && !redirect_valid_i && (occ < FQ_DEPTH);

    chk("inst_valid", 64'(inst_valid_o), 64'(exp_valid));
    chk("imem_req", 64'(imem_req_o), 64'(exp_req));
    if (exp_req) chk("imem_addr", 64'(imem_addr_o), 64'(m_pc[6:2]));
    chk("inst", 64'(inst_o), 64'(exp_head.inst));
    chk("inst_pc", inst_pc_o, exp_head.pc);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched_o, m_fetched);
    chk("perf_stall", perf_stall_o, m_stall);
`endif

    if (reset_i) begin
      resp = m_inflight && !m_kill;
      if (exp_valid) m_last = exp_head;
      if (exp_pop) void'(mq.pop_front());
      if (resp) begin
        e.pc   = m_req_pc;
        e.inst = word(int'(m_req_pc[6:2]));
        mq.push_back(e);
      end
      if (resp && !redirect_valid_i && m_fetched != '1) m_fetched++;
      if (exp_valid && !inst_ready_i && m_stall != '1) m_stall++;
      if (exp_req) m_req_pc = m_pc;
      if (redirect_valid_i) begin
        mq.delete();
        m_pc = {redirect_pc_i[63:2], 2'b00};
      end else if (exp_req) begin
        m_pc = m_pc + 64'd4;
      end
      m_inflight = exp_req;
      m_kill     = redirect_valid_i;
      m_run      = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_drv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic chk_head(input string name, input logic [63:0] pc, input logic [31:0] inst);
    chk({name, "_valid"}, 64'(inst_valid_o), 64'd1);
    chk({name, "_pc"}, inst_pc_o, pc);
    chk({name, "_inst"}, 64'(inst_o), 64'(inst));
  endtask

  // Redirect in cycle T, then land on the sampling point of T+3.
  task automatic redirect_to(input logic [63:0] tgt);
    to_drv();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = tgt;
    to_neg();
    chk("redir_no_req", 64'(imem_req_o), 64'd0);
    to_drv();
    redirect_valid_i = 1'b0;
    to_neg();
    chk("redir_t1_valid", 64'(inst_valid_o), 64'd0);
    chk("redir_t1_req", 64'(imem_req_o), 64'd1);
    to_drv();
    to_neg();
    chk("redir_t2_valid", 64'(inst_valid_o), 64'd0);
    to_drv();
    to_neg();
  endtask

  initial begin
    reset_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    inst_ready_i     = 1'b1;
    repeat (3) to_drv();
    to_neg();
    chk("rst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'h13);
    chk("rst_pc", inst_pc_o, 64'h0);

    // Release: first request one cycle later, first head three cycles later.
    to_drv();
    reset_i = 1'b1;
    to_neg();
    chk("start_r0_req", 64'(imem_req_o), 64'd0);
    to_drv(); to_neg();
    chk("start_r1_req", 64'(imem_req_o), 64'd1);
    chk("start_r1_addr", 64'(imem_addr_o), 64'd0);
    to_drv(); to_neg();
    chk("start_r2_valid", 64'(inst_valid_o), 64'd0);
    to_drv(); to_neg();
    chk_head("start_h0", 64'h0, 32'h1000_0000);
    to_drv(); to_neg();
    chk_head("start_h1", 64'h4, 32'h1000_0001);
    to_drv(); to_neg();
    chk_head("start_h2", 64'h8, 32'h1000_0002);

    // Backpressure: queue fills and requests stop.
    to_drv();
    inst_ready_i = 1'b0;
    repeat (4) begin to_neg(); to_drv(); end
    to_neg();
    chk("bp_req", 64'(imem_req_o), 64'd0);
    chk("bp_valid", 64'(inst_valid_o), 64'd1);
    to_drv();
    inst_ready_i = 1'b1;
    to_neg();

    // Redirect with entries queued and a word in flight.
    redirect_to(64'h40);
    chk_head("redir40", 64'h40, 32'h1000_0010);

    // Misaligned target rounds down.
    redirect_to(64'h4E);
    chk_head("redir4e", 64'h4C, 32'h1000_0013);

    // Memory index wraps while the PC keeps counting.
    redirect_to(64'h78);
    chk_head("wrap0", 64'h78, 32'h1000_001E);
    to_drv(); to_neg();
    chk_head("wrap1", 64'h7C, 32'h1000_001F);
    to_drv(); to_neg();
    chk_head("wrap2", 64'h80, 32'h1000_0000);
    to_drv(); to_neg();
    chk_head("wrap3", 64'h84, 32'h1000_0001);

    // Reset mid-stream clears outputs at once, then fetch restarts from RESET_PC.
    to_drv();
    reset_i = 1'b0;
    #1;
    chk("midrst_valid", 64'(inst_valid_o), 64'd0);
    chk("midrst_inst", 64'(inst_o), 64'h13);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_perf_f", perf_fetched_o, 64'd0);
    chk("midrst_perf_s", perf_stall_o, 64'd0);
`endif
    to_drv();
    to_drv();
    reset_i = 1'b1;
    repeat (3) begin to_neg(); to_drv(); end
    to_neg();
    chk_head("restart", 64'h0, 32'h1000_0000);

    // Randomized traffic, including redirects near the top of the address space.
    repeat (3000) begin
      to_drv();
      inst_ready_i     = ($urandom_range(0, 9) < 7);
      redirect_valid_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        redirect_pc_i = {$urandom(), $urandom()};
      reset_i = ($urandom_range(0, 299) != 0);
    end
    to_drv();
    reset_i          = 1'b1;
    redirect_valid_i = 1'b0;
    inst_ready_i     = 1'b1;
    repeat (4) to_drv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
